lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Script-driven command sequencer for the 8x8 LCD image controller.
//  - Fetches 4-bit opcodes from a synchronous script ROM.
//  - Issues each opcode to the LCD controller over its cmd/cmd_valid/busy handshake.
//  - Terminates the run with a WRITE and waits for the controller's done.
//  - Sits between the test/host start logic and the LCD controller.
// PARAMETERS
//  SCRIPT_AW       6    script ROM address width; script depth = 2**SCRIPT_AW
//  TIMEOUT_CYCLES  256  max cycles in any wait state (used only with LCD_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          asynchronous, active-high
//  start          in   1          1-cycle pulse; begins a run (honoured only in IDLE or DONE)
//  scr_rd         out  1          script ROM read enable
//  scr_A          out  SCRIPT_AW  script ROM address
//  scr_Q          in   4          script ROM data, valid 1 cycle after scr_rd/scr_A
//  lcd_cmd        out  4          opcode to LCD controller
//  lcd_cmd_valid  out  1          1-cycle issue strobe
//  lcd_busy       in   1          LCD controller busy
//  lcd_done       in   1          LCD controller done (image written out)
//  seq_busy       out  1          run in progress
//  seq_done       out  1          run completed; held until next start or reset
//  cmd_count      out  SCRIPT_AW+1  opcodes issued this run, including the final WRITE
//  seq_err        out  1          timeout flag; tied 0 without LCD_SEQ_TIMEOUT_EN
// BEHAVIOUR
//  Reset: all outputs 0, lcd_cmd=0, scr_A=0; state IDLE.
//  Opcodes: 0 WRITE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 MAX, 6 MIN, 7 AVG, 8 CCR, 9 CR,
//  10 MIRX, 11 MIRY. Opcodes 12-15 are skipped: not issued, not counted.
//  States:
//   IDLE/DONE --start--> FETCH: scr_A<=0, cmd_count<=0, seq_busy<=1, seq_done<=0.
//   FETCH: scr_rd=1 for 1 cycle -> WAITQ.
//   WAITQ: capture scr_Q into op_r.
//     Illegal opcode: last entry -> ISSUE with WRITE; otherwise scr_A+1, FETCH.
//     Legal opcode -> WAIT_RDY.
//   WAIT_RDY: stay while lcd_busy=1. This covers the controller's post-reset image load.
//   ISSUE: lcd_cmd<=op_r, lcd_cmd_valid=1 for exactly 1 cycle, cmd_count+1 -> WAIT_HI.
//   WAIT_HI: wait lcd_busy=1 -> WAIT_LO.
//   WAIT_LO: wait lcd_busy=0.
//     op_r=WRITE -> WAIT_DONE.
//     scr_A = last entry -> op_r<=WRITE, WAIT_RDY (forced final WRITE).
//     Otherwise scr_A+1 -> FETCH.
//   WAIT_DONE: wait lcd_done=1 -> DONE: seq_busy<=0, seq_done<=1.
//  lcd_cmd is held stable from ISSUE until exit of WAIT_LO/WAIT_DONE. The controller samples
//  cmd continuously while busy.
//  Opcodes after the first WRITE in the script are never fetched.
//  Address wrap: scr_A never wraps within a run; the last entry terminates the run.
//  start during a run (any state except IDLE/DONE) is ignored.
//  Async reset mid-run returns to IDLE in the same edge. No partial state survives.
//  Worst-case overhead per opcode, excluding LCD busy time: 4 cycles (FETCH, WAITQ, WAIT_RDY, ISSUE).
// CONFIGURATION
//  LCD_SEQ_TIMEOUT_EN defined:
//   - Counter clears on each state entry and counts cycles spent in WAIT_RDY, WAIT_HI,
//     WAIT_LO and WAIT_DONE.
//   - Reaching TIMEOUT_CYCLES -> state ERR: seq_err<=1, seq_busy<=0, seq_done stays 0,
//     lcd_cmd_valid 0.
//   - ERR exits only via reset.
//  Not defined: waits are unbounded, seq_err tied 0, no counter logic instantiated.
// STRUCTURE
//  Package lcd_seq_pkg: opcode localparams (CMD_WRITE..CMD_MIRY), CMD_LAST=11,
//  state encoding localparams (IDLE, FETCH, WAITQ, WAIT_RDY, ISSUE, WAIT_HI, WAIT_LO,
//  WAIT_DONE, DONE, ERR).
//  Sub-module lcd_seq_timer: clear/enable/expired counter sized from TIMEOUT_CYCLES.
//  Instantiated only under LCD_SEQ_TIMEOUT_EN.
// TESTING
//  1. Script {4,4,2,5,0}, lcd busy 3 cycles per cmd -> 5 valid strobes with cmds 4,4,2,5,0
//     in order; cmd_count=5; seq_done=1 one cycle after lcd_done.
//  2. Start immediately after reset, lcd_busy=1 for 70 cycles -> no lcd_cmd_valid before
//     lcd_busy falls; first issue on the 2nd cycle after the fall.
//  3. Script of 64 entries all =1, no WRITE -> 64 UP strobes plus one forced WRITE;
//     cmd_count=65; scr_A ends at 63.
//  4. Script {13,15,7,0} -> only 7 and 0 issued; cmd_count=2.
//  5. Reset asserted in WAIT_LO mid-run -> all outputs 0 next edge; new start reruns
//     from scr_A=0.
//  6. LCD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, lcd_busy never rises after issue ->
//     seq_err=1 16 cycles after ISSUE; seq_done=0; start is ignored.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared opcodes, state encoding and opcode helper for the LCD command sequencer.
package lcd_seq_pkg;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_CCR   = 4'd8;
  localparam logic [3:0] CMD_CR    = 4'd9;
  localparam logic [3:0] CMD_MIRX  = 4'd10;
  localparam logic [3:0] CMD_MIRY  = 4'd11;
  localparam logic [3:0] CMD_LAST  = 4'd11;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    WAITQ     = 4'd2,
    WAIT_RDY  = 4'd3,
    ISSUE     = 4'd4,
    WAIT_HI   = 4'd5,
    WAIT_LO   = 4'd6,
    WAIT_DONE = 4'd7,
    DONE      = 4'd8,
    ERR       = 4'd9
  } seq_state_t;

  function automatic logic isLegalOp(input logic [3:0] op);
    return op <= CMD_LAST;
  endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Wait-state watchdog: clears on request, counts enabled cycles, flags the last allowed cycle.
module lcd_seq_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_enable && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_clear)
      r_cnt <= '0;
    else if (i_enable && !o_expired)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Script-driven opcode sequencer feeding the 8x8 LCD image controller.
// Optional wait-state watchdog enabled by defining LCD_SEQ_TIMEOUT_EN.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int SCRIPT_AW      = 6,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  output logic                 o_scr_rd,
  output logic [SCRIPT_AW-1:0] o_scr_A,
  input  logic [3:0]           i_scr_Q,
  output logic [3:0]           o_lcd_cmd,
  output logic                 o_lcd_cmd_valid,
  input  logic                 i_lcd_busy,
  input  logic                 i_lcd_done,
  output logic                 o_seq_busy,
  output logic                 o_seq_done,
  output logic [SCRIPT_AW:0]   o_cmd_count,
  output logic                 o_seq_err
);

  seq_state_t           r_state, w_state_next;
  logic [SCRIPT_AW-1:0] r_scr_A, w_scr_A_next;
  logic [3:0]           r_op, w_op_next;
  logic [3:0]           r_lcd_cmd, w_lcd_cmd_next;
  logic [SCRIPT_AW:0]   r_cmd_count, w_cmd_count_next;
  logic                 r_seq_busy, w_seq_busy_next;
  logic                 r_seq_done, w_seq_done_next;
  logic                 w_scr_rd, w_cmd_valid;
  logic                 w_last;
  logic                 w_expired;

  assign w_last = (r_scr_A == {SCRIPT_AW{1'b1}});

`ifdef LCD_SEQ_TIMEOUT_EN
  logic w_in_wait;
  assign w_in_wait = (r_state == WAIT_RDY) || (r_state == WAIT_HI) ||
                     (r_state == WAIT_LO)  || (r_state == WAIT_DONE);

  lcd_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_state_next != r_state),
    .i_enable (w_in_wait),
    .o_expired(w_expired)
  );

  assign o_seq_err = (r_state == ERR);
`else
  assign w_expired = 1'b0;
  assign o_seq_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_scr_A     <= '0;
      r_op        <= CMD_WRITE;
      r_lcd_cmd   <= '0;
      r_cmd_count <= '0;
      r_seq_busy  <= 1'b0;
      r_seq_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_scr_A     <= w_scr_A_next;
      r_op        <= w_op_next;
      r_lcd_cmd   <= w_lcd_cmd_next;
      r_cmd_count <= w_cmd_count_next;
      r_seq_busy  <= w_seq_busy_next;
      r_seq_done  <= w_seq_done_next;
    end
  end

  // lcd_cmd is loaded on entry to ISSUE so it is already valid alongside the strobe.
  always_comb begin
    w_state_next     = r_state;
    w_scr_A_next     = r_scr_A;
    w_op_next        = r_op;
    w_lcd_cmd_next   = r_lcd_cmd;
    w_cmd_count_next = r_cmd_count;
    w_seq_busy_next  = r_seq_busy;
    w_seq_done_next  = r_seq_done;
    w_scr_rd         = 1'b0;
    w_cmd_valid      = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state_next     = FETCH;
          w_scr_A_next     = '0;
          w_cmd_count_next = '0;
          w_seq_busy_next  = 1'b1;
          w_seq_done_next  = 1'b0;
        end
      end
      FETCH: begin
        w_scr_rd     = 1'b1;
        w_state_next = WAITQ;
      end
      WAITQ: begin
        w_op_next = i_scr_Q;
        if (isLegalOp(i_scr_Q)) begin
          w_state_next = WAIT_RDY;
        end else if (w_last) begin
          w_op_next      = CMD_WRITE;
          w_lcd_cmd_next = CMD_WRITE;
          w_state_next   = ISSUE;
        end else begin
          w_scr_A_next = r_scr_A + 1'b1;
          w_state_next = FETCH;
        end
      end
      WAIT_RDY: begin
        if (!i_lcd_busy) begin
          w_lcd_cmd_next = r_op;
          w_state_next   = ISSUE;
        end
      end
      ISSUE: begin
        w_cmd_valid      = 1'b1;
        w_cmd_count_next = r_cmd_count + 1'b1;
        w_state_next     = WAIT_HI;
      end
      WAIT_HI: begin
        if (i_lcd_busy)
          w_state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!i_lcd_busy) begin
          if (r_op == CMD_WRITE) begin
            w_state_next = WAIT_DONE;
          end else if (w_last) begin
            w_op_next    = CMD_WRITE;
            w_state_next = WAIT_RDY;
          end else begin
            w_scr_A_next = r_scr_A + 1'b1;
            w_state_next = FETCH;
          end
        end
      end
      WAIT_DONE: begin
        if (i_lcd_done) begin
          w_state_next    = DONE;
          w_seq_busy_next = 1'b0;
          w_seq_done_next = 1'b1;
        end
      end
      ERR: begin
        w_state_next = ERR;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_expired) begin
      w_state_next    = ERR;
      w_seq_busy_next = 1'b0;
      w_seq_done_next = 1'b0;
    end
  end

  assign o_scr_rd        = w_scr_rd;
  assign o_scr_A         = r_scr_A;
  assign o_lcd_cmd       = r_lcd_cmd;
  assign o_lcd_cmd_valid = w_cmd_valid;
  assign o_seq_busy      = r_seq_busy;
  assign o_seq_done      = r_seq_done;
  assign o_cmd_count     = r_cmd_count;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with a script ROM and a simple LCD controller model.
module tb_lcd_cmd_sequencer;

  localparam int AW     = 6;
  localparam int TO_CYC = 16;
`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int BUSY_HOLD = 10;
`else
  localparam int BUSY_HOLD = 70;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          scrRd;
  logic [AW-1:0] scrA;
  logic [3:0]    scrQ = 4'd0;
  logic [3:0]    lcdCmd;
  logic          cmdValid;
  logic          lcdBusy;
  logic          lcdDone;
  logic          seqBusy, seqDone, seqErr;
  logic [AW:0]   cmdCount;

  logic [3:0] rom [64];
  int         busyLen = 3;
  logic       forceBusy = 1'b0;
  logic       noResp = 1'b0;
  int         busyCnt;
  logic       pendingDone;
  int         cyc = 0;

  logic [3:0] logCmds[$];
  int         firstValidCyc = -1;
  int         firstScrA = -1;
  int         nTests = 0;
  int         nFail = 0;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(.SCRIPT_AW(AW), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (start),
    .o_scr_rd       (scrRd),
    .o_scr_A        (scrA),
    .i_scr_Q        (scrQ),
    .o_lcd_cmd      (lcdCmd),
    .o_lcd_cmd_valid(cmdValid),
    .i_lcd_busy     (lcdBusy),
    .i_lcd_done     (lcdDone),
    .o_seq_busy     (seqBusy),
    .o_seq_done     (seqDone),
    .o_cmd_count    (cmdCount),
    .o_seq_err      (seqErr)
  );

  always @(posedge clk) if (scrRd) scrQ <= rom[scrA];
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy for busyLen cycles after each strobe, done pulse after a WRITE finishes.
  assign lcdBusy = forceBusy || (busyCnt != 0);
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busyCnt     <= 0;
      pendingDone <= 1'b0;
      lcdDone     <= 1'b0;
    end else begin
      lcdDone <= 1'b0;
      if (cmdValid && !noResp) begin
        busyCnt     <= busyLen;
        pendingDone <= (lcdCmd == 4'd0);
      end else if (busyCnt > 0) begin
        busyCnt <= busyCnt - 1;
      end else if (pendingDone) begin
        lcdDone     <= 1'b1;
        pendingDone <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmdValid) begin
      logCmds.push_back(lcdCmd);
      if (firstValidCyc < 0) firstValidCyc = cyc;
    end
    if (scrRd && firstScrA < 0) firstScrA = int'(scrA);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    logCmds.delete();
    firstValidCyc = -1;
    firstScrA = -1;
  endtask

  task automatic fillRom(input logic [3:0] v);
    for (int i = 0; i < 64; i++) rom[i] = v;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " scr_rd"}, 32'(scrRd), 0);
    checkOutput({tag, " scr_A"}, 32'(scrA), 0);
    checkOutput({tag, " lcd_cmd"}, 32'(lcdCmd), 0);
    checkOutput({tag, " lcd_cmd_valid"}, 32'(cmdValid), 0);
    checkOutput({tag, " seq_busy"}, 32'(seqBusy), 0);
    checkOutput({tag, " seq_done"}, 32'(seqDone), 0);
    checkOutput({tag, " cmd_count"}, 32'(cmdCount), 0);
    checkOutput({tag, " seq_err"}, 32'(seqErr), 0);
  endtask

  task automatic runToDone(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcdDone && n < budget);
    if (!lcdDone) begin
      checkOutput({tag, " lcd_done timeout"}, 0, 1);
    end else begin
      checkOutput({tag, " seq_done with lcd_done"}, 32'(seqDone), 0);
      @(negedge clk);
      checkOutput({tag, " seq_done next cycle"}, 32'(seqDone), 1);
      checkOutput({tag, " seq_busy at end"}, 32'(seqBusy), 0);
    end
  endtask

  task automatic checkLog(input string tag, input logic [3:0] expQ[$]);
    checkOutput({tag, " strobes"}, logCmds.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < logCmds.size(); i++)
      checkOutput($sformatf("%s cmd[%0d]", tag, i), 32'(logCmds[i]), 32'(expQ[i]));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    logic [3:0] expQ[$];
    int n;
    int ones;

    // Reset state
    fillRom(4'd1);
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    // Basic script with a WRITE terminator
    rom[0] = 4'd4; rom[1] = 4'd4; rom[2] = 4'd2; rom[3] = 4'd5; rom[4] = 4'd0;
    busyLen = 3;
    clearLog();
    applyStimulus();
    checkOutput("t1 seq_busy in run", 32'(seqBusy), 1);
    runToDone("t1", 400);
    expQ = '{4'd4, 4'd4, 4'd2, 4'd5, 4'd0};
    checkLog("t1", expQ);
    checkOutput("t1 cmd_count", 32'(cmdCount), 5);
    checkOutput("t1 seq_err", 32'(seqErr), 0);

    // Controller busy after reset delays the first issue
    forceBusy = 1'b1;
    applyReset();
    fillRom(4'd1);
    rom[0] = 4'd3; rom[1] = 4'd0;
    clearLog();
    applyStimulus();
    repeat (BUSY_HOLD) @(negedge clk);
    checkOutput("t2 no issue while busy", logCmds.size(), 0);
    @(posedge clk);
    #1 forceBusy = 1'b0;
    n = cyc;
    runToDone("t2", 200);
    checkOutput("t2 issue delay", 32'(firstValidCyc - n), 1);
    expQ = '{4'd3, 4'd0};
    checkLog("t2", expQ);

    // Full script without WRITE: forced final WRITE on the last entry
    fillRom(4'd1);
    busyLen = 1;
    clearLog();
    applyStimulus();
    runToDone("t3", 2000);
    checkOutput("t3 strobes", logCmds.size(), 65);
    ones = 0;
    for (int i = 0; i < logCmds.size() && i < 64; i++)
      if (logCmds[i] == 4'd1) ones++;
    checkOutput("t3 up strobes", ones, 64);
    if (logCmds.size() > 0)
      checkOutput("t3 final cmd", 32'(logCmds[logCmds.size()-1]), 0);
    checkOutput("t3 cmd_count", 32'(cmdCount), 65);
    checkOutput("t3 scr_A end", 32'(scrA), 63);

    // Illegal opcodes are skipped
    fillRom(4'd1);
    rom[0] = 4'd13; rom[1] = 4'd15; rom[2] = 4'd7; rom[3] = 4'd0;
    busyLen = 2;
    clearLog();
    applyStimulus();
    runToDone("t4", 400);
    expQ = '{4'd7, 4'd0};
    checkLog("t4", expQ);
    checkOutput("t4 cmd_count", 32'(cmdCount), 2);

    // Reset in WAIT_LO, then a clean rerun
    fillRom(4'd1);
    rom[0] = 4'd4; rom[1] = 4'd4; rom[2] = 4'd2; rom[3] = 4'd5; rom[4] = 4'd0;
    busyLen = 5;
    clearLog();
    applyStimulus();
    n = 0; ones = 0;
    while (ones < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (cmdValid) ones++;
    end
    checkOutput("t5 second strobe seen", ones, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcdBusy && n < 20);
    checkOutput("t5 busy seen", 32'(lcdBusy), 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 checkAllZero("t5 mid-run reset");
    @(negedge clk);
    reset = 1'b0;
    clearLog();
    applyStimulus();
    runToDone("t5", 400);
    checkOutput("t5 first fetch addr", firstScrA, 0);
    expQ = '{4'd4, 4'd4, 4'd2, 4'd5, 4'd0};
    checkLog("t5", expQ);
    checkOutput("t5 cmd_count", 32'(cmdCount), 5);

`ifdef LCD_SEQ_TIMEOUT_EN
    // Controller never answers: watchdog ends the run in ERR
    applyReset();
    noResp = 1'b1;
    fillRom(4'd1);
    rom[0] = 4'd4; rom[1] = 4'd0;
    clearLog();
    applyStimulus();
    n = 0;
    while (!cmdValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6 strobe seen", 32'(cmdValid), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!seqErr && n < 100);
    checkOutput("t6 wait cycles before err", 32'(n - 1), 16);
    checkOutput("t6 seq_done", 32'(seqDone), 0);
    checkOutput("t6 seq_busy", 32'(seqBusy), 0);
    checkOutput("t6 valid in err", 32'(cmdValid), 0);
    applyStimulus();
    repeat (5) @(negedge clk);
    checkOutput("t6 err held", 32'(seqErr), 1);
    checkOutput("t6 start ignored busy", 32'(seqBusy), 0);
    checkOutput("t6 start ignored strobes", logCmds.size(), 1);
    noResp = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
